// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MA_IDLE,
        MA_READ,
        MA_WRITE
    } ma_state_e;

    typedef enum logic {
        OWN_FETCH,
        OWN_LSB
    } ma_owner_e;

    // lsb_len encoding: number of bytes is 1 << code, code 3 behaves as 4 bytes
    localparam logic [1:0] LEN_1B = 2'd0;
    localparam logic [1:0] LEN_2B = 2'd1;
    localparam logic [1:0] LEN_4B = 2'd2;

    localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;

    function automatic logic [2:0] len_bytes(input logic [1:0] code);
        case (code)
            LEN_1B:  len_bytes = 3'd1;
            LEN_2B:  len_bytes = 3'd2;
            default: len_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and RAM-side signals of the memory arbiter.
interface mem_arbiter_if;

    logic        flush;
    logic        if_en;
    logic [31:0] if_addr;
    logic        if_rdy;
    logic [31:0] if_data;
    logic        if_is_compressed;
    logic        lsb_en;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_rdy;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  flush, if_en, if_addr, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
               mem_din, io_buffer_full,
        output if_rdy, if_data, if_is_compressed, lsb_rdy, lsb_rdata,
               mem_dout, mem_a, mem_wr
    );

    modport master (
        output flush, if_en, if_addr, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
               mem_din, io_buffer_full,
        input  if_rdy, if_data, if_is_compressed, lsb_rdy, lsb_rdata,
               mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and the
// load/store buffer, streaming each access byte by byte.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    mem_arbiter_if.slave  bus
);

    ma_state_e   state;
    ma_owner_e   owner;
    logic [2:0]  cnt;
    logic [2:0]  recv;
    logic [2:0]  len;
    logic        prio_lsb;
    logic [31:0] rd_buf;
    logic [31:0] base;
    logic [31:0] wdata;
    logic        rd_issue;
    logic        rd_pend;

    logic        if_rdy_q;
    logic [31:0] if_data_q;
    logic        if_cmp_q;
    logic        lsb_rdy_q;
    logic [31:0] lsb_rdata_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic        mem_wr_q;

    logic        capture;
    logic [31:0] assembled;
    logic        early;
    logic [2:0]  len_eff;
    logic        last_rd;
    logic [2:0]  wr_idx;
    logic        wr_last;
    logic [31:0] wr_addr;
    logic        io_stall;
    logic        grant_io_stall;
    logic        can_grant;
    logic        pick_lsb;

    // rd_issue: mem_a holds a read address this cycle; rd_pend: mem_din carries its byte
    always_comb begin
        capture   = (state == MA_READ) && rd_pend;
        assembled = rd_buf;
        assembled[8*recv[1:0] +: 8] = bus.mem_din;
        early     = capture && (owner == OWN_FETCH) && (recv == '0)
                    && (bus.mem_din[1:0] != 2'b11);
        len_eff   = early ? 3'd2 : len;
        last_rd   = capture && ((recv + 3'd1) == len_eff);
        wr_idx    = cnt + {2'b00, mem_wr_q};
        wr_last   = mem_wr_q && ((cnt + 3'd1) == len);
        wr_addr   = base + {29'd0, wr_idx};
        io_stall  = (wr_addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;
        grant_io_stall = (bus.lsb_addr[17:16] == IO_ADDR_HI) && bus.io_buffer_full;
        can_grant = !if_rdy_q && !lsb_rdy_q && !bus.flush;
        pick_lsb  = bus.lsb_en && (!bus.if_en || prio_lsb);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= MA_IDLE;
            owner       <= OWN_FETCH;
            cnt         <= '0;
            recv        <= '0;
            len         <= '0;
            prio_lsb    <= 1'b1;
            rd_buf      <= '0;
            base        <= '0;
            wdata       <= '0;
            rd_issue    <= 1'b0;
            rd_pend     <= 1'b0;
            if_rdy_q    <= 1'b0;
            if_data_q   <= '0;
            if_cmp_q    <= 1'b0;
            lsb_rdy_q   <= 1'b0;
            lsb_rdata_q <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
        end else if (rdy_in) begin
            if_rdy_q  <= 1'b0;
            lsb_rdy_q <= 1'b0;
            case (state)
                MA_IDLE: begin
                    mem_a_q    <= '0;
                    mem_dout_q <= '0;
                    mem_wr_q   <= 1'b0;
                    rd_issue   <= 1'b0;
                    rd_pend    <= 1'b0;
                    if (can_grant && (bus.if_en || bus.lsb_en)) begin
                        if (bus.if_en && bus.lsb_en) prio_lsb <= !pick_lsb;
                        rd_buf <= '0;
                        recv   <= '0;
                        if (pick_lsb) begin
                            owner   <= OWN_LSB;
                            base    <= bus.lsb_addr;
                            wdata   <= bus.lsb_wdata;
                            len     <= len_bytes(bus.lsb_len);
                            mem_a_q <= bus.lsb_addr;
                            if (bus.lsb_wr) begin
                                state      <= MA_WRITE;
                                cnt        <= '0;
                                mem_dout_q <= bus.lsb_wdata[7:0];
                                mem_wr_q   <= !grant_io_stall;
                            end else begin
                                state    <= MA_READ;
                                cnt      <= 3'd1;
                                rd_issue <= 1'b1;
                            end
                        end else begin
                            owner    <= OWN_FETCH;
                            base     <= bus.if_addr;
                            len      <= 3'd4;
                            state    <= MA_READ;
                            cnt      <= 3'd1;
                            mem_a_q  <= bus.if_addr;
                            rd_issue <= 1'b1;
                        end
                    end
                end
                MA_READ: begin
                    if (bus.flush) begin
                        state    <= MA_IDLE;
                        mem_a_q  <= '0;
                        rd_issue <= 1'b0;
                        rd_pend  <= 1'b0;
                    end else begin
                        rd_pend <= rd_issue;
                        if (early) len <= 3'd2;
                        if (capture) begin
                            rd_buf <= assembled;
                            recv   <= recv + 3'd1;
                        end
                        if (last_rd) begin
                            state    <= MA_IDLE;
                            mem_a_q  <= '0;
                            rd_issue <= 1'b0;
                            rd_pend  <= 1'b0;
                            if (owner == OWN_FETCH) begin
                                if_rdy_q  <= 1'b1;
                                if_data_q <= assembled;
                                if_cmp_q  <= (assembled[1:0] != 2'b11);
                            end else begin
                                lsb_rdy_q   <= 1'b1;
                                lsb_rdata_q <= assembled;
                            end
                        end else if (cnt < len_eff) begin
                            mem_a_q  <= base + {29'd0, cnt};
                            cnt      <= cnt + 3'd1;
                            rd_issue <= 1'b1;
                        end else begin
                            mem_a_q  <= '0;
                            rd_issue <= 1'b0;
                        end
                    end
                end
                MA_WRITE: begin
                    // stores ignore flush: once granted they always commit
                    if (wr_last) begin
                        state      <= MA_IDLE;
                        lsb_rdy_q  <= 1'b1;
                        mem_a_q    <= '0;
                        mem_dout_q <= '0;
                        mem_wr_q   <= 1'b0;
                    end else begin
                        cnt        <= wr_idx;
                        mem_a_q    <= wr_addr;
                        mem_dout_q <= wdata[8*wr_idx[1:0] +: 8];
                        mem_wr_q   <= !io_stall;
                    end
                end
                default: state <= MA_IDLE;
            endcase
        end
    end

    assign bus.if_rdy           = if_rdy_q;
    assign bus.if_data          = if_data_q;
    assign bus.if_is_compressed = if_cmp_q;
    assign bus.lsb_rdy          = lsb_rdy_q;
    assign bus.lsb_rdata        = lsb_rdata_q;
    assign bus.mem_a            = mem_a_q;
    assign bus.mem_dout         = mem_dout_q;
    assign bus.mem_wr           = mem_wr_q && rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small RAM model.
module tb_mem_arbiter;

    logic clk_in;
    logic rst_in;
    logic rdy_in;

    mem_arbiter_if bus ();

    mem_arbiter #(.IO_ADDR_HI(2'b11)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    logic [7:0]  ram [0:65535];
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [31:0] last_wa = '0;
    logic [7:0]  last_wd = '0;
    logic [31:0] wr_word = '0;
    logic        saw67 = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // synchronous-read RAM that stalls together with the core
    always @(posedge clk_in) begin
        if (rdy_in) bus.mem_din <= ram[bus.mem_a[15:0]];
        if (bus.mem_wr) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= bus.mem_a;
            last_wd <= bus.mem_dout;
            wr_word[8*bus.mem_a[1:0] +: 8] <= bus.mem_dout;
        end
    end

    always @(negedge clk_in)
        if (bus.mem_a == 32'h6 || bus.mem_a == 32'h7) saw67 <= 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    // Waits for the chosen rdy pulse; lat is its cycle offset from t0, -1 on timeout.
    task automatic wait_rdy(input bit lsb, input int t0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (lsb ? bus.lsb_rdy : bus.if_rdy) begin
                lat = cyc - t0;
                break;
            end
        end
        if (lsb) bus.lsb_en = 1'b0;
        else     bus.if_en  = 1'b0;
    endtask

    task automatic lsb_req(input logic wr, input logic [1:0] ln,
                           input logic [31:0] a, input logic [31:0] d);
        bus.lsb_en    = 1'b1;
        bus.lsb_wr    = wr;
        bus.lsb_len   = ln;
        bus.lsb_addr  = a;
        bus.lsb_wdata = d;
    endtask

    initial begin
        int t0;
        int lat;
        int w0;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[0]  = 8'h13; ram[1]  = 8'h05;
        ram[4]  = 8'h01; ram[5]  = 8'h45; ram[6] = 8'h99; ram[7] = 8'h99;
        ram[8]  = 8'h93; ram[9]  = 8'h00; ram[10] = 8'h10;
        ram[12] = 8'h13;
        ram[16] = 8'hB7;
        ram[32] = 8'h37; ram[33] = 8'h01;
        ram[64] = 8'h11; ram[65] = 8'h22; ram[66] = 8'h33; ram[67] = 8'h44;
        ram[256] = 8'hAA; ram[257] = 8'hBB;

        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.flush = 1'b0; bus.if_en = 1'b0; bus.if_addr = '0;
        bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = '0;
        bus.lsb_addr = '0; bus.lsb_wdata = '0; bus.io_buffer_full = 1'b0;

        repeat (2) @(negedge clk_in);
        chk("rst_if_rdy",   {31'd0, bus.if_rdy}, 32'd0);
        chk("rst_if_data",  bus.if_data, 32'd0);
        chk("rst_if_cmp",   {31'd0, bus.if_is_compressed}, 32'd0);
        chk("rst_lsb_rdy",  {31'd0, bus.lsb_rdy}, 32'd0);
        chk("rst_lsb_data", bus.lsb_rdata, 32'd0);
        chk("rst_mem_a",    bus.mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst_mem_wr",   {31'd0, bus.mem_wr}, 32'd0);
        next_cycle();
        rst_in = 1'b0;

        // full 32-bit fetch
        next_cycle();
        bus.if_addr = 32'h0; bus.if_en = 1'b1; t0 = cyc;
        wait_rdy(1'b0, t0, lat);
        chk("fetch0_lat",  lat, 32'd6);
        chk("fetch0_data", bus.if_data, 32'h0000_0513);
        chk("fetch0_cmp",  {31'd0, bus.if_is_compressed}, 32'd0);

        // compressed fetch ends after two bytes
        next_cycle();
        bus.if_addr = 32'h4; bus.if_en = 1'b1; t0 = cyc;
        wait_rdy(1'b0, t0, lat);
        chk("fetch4_lat",  lat, 32'd4);
        chk("fetch4_data", bus.if_data, 32'h0000_4501);
        chk("fetch4_cmp",  {31'd0, bus.if_is_compressed}, 32'd1);
        repeat (3) @(negedge clk_in);
        chk("fetch4_no_addr67", {31'd0, saw67}, 32'd0);

        // simultaneous requests: LSB first after reset, then fetch
        next_cycle();
        bus.if_addr = 32'h8; bus.if_en = 1'b1;
        lsb_req(1'b0, 2'd2, 32'h40, 32'h0);
        t0 = cyc;
        wait_rdy(1'b1, t0, lat);
        chk("rr1_lsb_lat",  lat, 32'd6);
        chk("rr1_lsb_data", bus.lsb_rdata, 32'h4433_2211);
        t0 = cyc;
        wait_rdy(1'b0, t0, lat);
        chk("rr1_if_lat",  lat, 32'd7);
        chk("rr1_if_data", bus.if_data, 32'h0010_0093);

        // second collision: fetch wins this time
        next_cycle();
        bus.if_addr = 32'hC; bus.if_en = 1'b1;
        lsb_req(1'b0, 2'd0, 32'h41, 32'h0);
        t0 = cyc;
        wait_rdy(1'b0, t0, lat);
        chk("rr2_if_lat",  lat, 32'd6);
        chk("rr2_if_data", bus.if_data, 32'h0000_0013);
        t0 = cyc;
        wait_rdy(1'b1, t0, lat);
        chk("rr2_lsb_lat",  lat, 32'd4);
        chk("rr2_lsb_data", bus.lsb_rdata, 32'h0000_0022);

        // illegal length code 3 reads four bytes
        next_cycle();
        lsb_req(1'b0, 2'd3, 32'h40, 32'h0); t0 = cyc;
        wait_rdy(1'b1, t0, lat);
        chk("len3_lat",  lat, 32'd6);
        chk("len3_data", bus.lsb_rdata, 32'h4433_2211);

        // IO store stalled by a full buffer for three cycles
        next_cycle();
        w0 = wr_cnt;
        bus.io_buffer_full = 1'b1;
        lsb_req(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041); t0 = cyc;
        repeat (3) next_cycle();
        bus.io_buffer_full = 1'b0;
        wait_rdy(1'b1, t0, lat);
        chk("io_lat",    lat, 32'd5);
        chk("io_writes", wr_cnt - w0, 32'd1);
        chk("io_addr",   last_wa, 32'h0003_0000);
        chk("io_data",   {24'd0, last_wd}, 32'h41);
        chk("io_if_data_held", bus.if_data, 32'h0000_0013);

        // flush aborts a fetch; refetch at the corrected PC
        next_cycle();
        bus.if_addr = 32'h10; bus.if_en = 1'b1; t0 = cyc;
        repeat (3) next_cycle();
        bus.flush = 1'b1; bus.if_en = 1'b0; bus.if_addr = 32'h20;
        next_cycle();
        bus.flush = 1'b0; bus.if_en = 1'b1; t0 = cyc;
        @(negedge clk_in);
        chk("flush_idle_mem_a", bus.mem_a, 32'd0);
        chk("flush_no_if_rdy",  {31'd0, bus.if_rdy}, 32'd0);
        wait_rdy(1'b0, t0, lat);
        chk("refetch_lat",  lat, 32'd6);
        chk("refetch_data", bus.if_data, 32'h0000_0137);

        // flush does not cancel a store in progress
        next_cycle();
        w0 = wr_cnt;
        lsb_req(1'b1, 2'd2, 32'h200, 32'hDDCC_BBAA); t0 = cyc;
        repeat (2) next_cycle();
        bus.flush = 1'b1;
        next_cycle();
        bus.flush = 1'b0;
        wait_rdy(1'b1, t0, lat);
        chk("st_flush_lat",    lat, 32'd5);
        chk("st_flush_writes", wr_cnt - w0, 32'd4);
        chk("st_flush_word",   wr_word, 32'hDDCC_BBAA);
        chk("st_flush_last_a", last_wa, 32'h203);

        // global enable dropped for two cycles mid-load
        next_cycle();
        lsb_req(1'b0, 2'd1, 32'h100, 32'h0); t0 = cyc;
        repeat (2) next_cycle();
        rdy_in = 1'b0;
        repeat (2) next_cycle();
        rdy_in = 1'b1;
        wait_rdy(1'b1, t0, lat);
        chk("stall_lat",  lat, 32'd6);
        chk("stall_data", bus.lsb_rdata, 32'h0000_BBAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between instruction fetch (Decoder) and the load/store buffer (LSB). It sequences each multi-byte access as a byte stream, assembles read data, detects compressed instructions during fetch, and returns a one-cycle ready pulse to the granted requester. It sits between the core front/back end and the external RAM/IO bus.

## Interface
- `IO_ADDR_HI`, default 2'b11: value of `addr[17:16]` that marks an IO address. Writes to IO addresses obey `io_buffer_full`.
- `clk_in` input 1: clock.
- `rst_in` input 1: asynchronous, active-high reset.
- `rdy_in` input 1: global enable. When low, all state is frozen and `mem_wr`=0.
- `flush` input 1: misprediction flush, qualified by `rdy_in`.
- `if_en` input 1: fetch request, held until `if_rdy`.
- `if_addr` input 32: fetch PC.
- `if_rdy` output 1: one-cycle pulse; fetch data valid.
- `if_data` output 32: instruction; upper 16 bits are zero when compressed.
- `if_is_compressed` output 1: fetched halfword has `[1:0]`≠2'b11.
- `lsb_en` input 1: LSB request, held until `lsb_rdy`.
- `lsb_wr` input 1: 1 = store, 0 = load.
- `lsb_len` input 2: byte count. 0→1, 1→2, 2→4 bytes; 3 is illegal and treated as 4.
- `lsb_addr` input 32: byte address.
- `lsb_wdata` input 32: store data, little-endian, low bytes used.
- `lsb_rdy` output 1: one-cycle pulse; access complete.
- `lsb_rdata` output 32: load data, zero-extended raw bytes. Sign extension belongs to the LSB.
- `mem_din` input 8: RAM read byte, valid one cycle after its address.
- `mem_dout` output 8: RAM write byte.
- `mem_a` output 32: RAM byte address.
- `mem_wr` output 1: 1 = write this cycle.
- `io_buffer_full` input 1: IO UART buffer full.

## Operation
- States: IDLE, READ, WRITE. Registers:
  - `owner` (FETCH/LSB)
  - `cnt` (bytes issued, 0..4)
  - `recv` (bytes captured)
  - `len` (1/2/4)
  - `prio_lsb`
  - `buf[31:0]`
- IDLE grant:
  - No grant in a cycle where `if_rdy` or `lsb_rdy` is high, because the requester's `en` may still be high.
  - Both requesting: the grant goes to LSB if `prio_lsb`, else FETCH. `prio_lsb` then toggles to favour the loser (round-robin).
  - One requesting: that requester is granted.
- FETCH grant: enter READ with len=4. After byte 1 is captured, if `buf[1:0]`≠2'b11 the access ends early as compressed (2 bytes). No further address is issued beyond the byte already in flight, and a byte arriving for an early-ended access is discarded.
- LSB load: READ with `len` from `lsb_len`. LSB store: WRITE.
- READ:
  - Issue `mem_a`=base+`cnt` while `cnt`<len.
  - Capture `mem_din` into `buf[8*recv+:8]`.
  - When the last byte is captured, pulse the owner's rdy with data and return to IDLE.
- WRITE:
  - Each cycle drive `mem_a`=base+`cnt`, `mem_dout`=byte `cnt`, `mem_wr`=1.
  - If the address is IO (`addr[17:16]`==`IO_ADDR_HI`) and `io_buffer_full`=1, drive `mem_wr`=0 and hold `cnt`.
  - After the last byte, pulse `lsb_rdy` and return to IDLE.
- Flush (`flush`&&`rdy_in`):
  - Aborts a fetch or load immediately: state goes to IDLE, no rdy pulse, in-flight read byte discarded.
  - A store in progress is committed and completes normally, including its `lsb_rdy`.
  - A flush in IDLE blocks grants that cycle.
- Outside WRITE, `mem_a`=0 and `mem_dout`=0 whenever no access is issuing.

## Timing
- Reset: state=IDLE, `prio_lsb`=1, `cnt`/`recv`/`buf`=0. All outputs are 0: `if_rdy`, `if_data`, `if_is_compressed`, `lsb_rdy`, `lsb_rdata`, `mem_a`, `mem_dout`, `mem_wr`.
- All outputs are registered.
- Request seen in IDLE at cycle T:
  - The first address appears at T+1.
  - N-byte read: byte k is addressed at T+1+k and arrives at T+2+k; rdy is high at T+N+2. Full fetch: rdy at T+6. Compressed fetch: rdy at T+4. 1-byte load: rdy at T+3.
  - N-byte store with no stall: byte k is written at T+1+k; `lsb_rdy` at T+N+1. Each IO-full cycle adds one cycle.
- Data outputs hold their value until the next rdy pulse for the same requester.
- Back-to-back: the earliest next grant is the cycle after the rdy pulse.
- `rdy_in` low mid-access: nothing advances. The byte on `mem_din` is recaptured when resuming, because the RAM holds its output when the address is unchanged.

## Structure
- Add to `params.v`: the MA_IDLE/MA_READ/MA_WRITE encodings, the `lsb_len` encoding, and `IO_ADDR_HI`.
- Single module; no sub-module. Byte assembly and the address counter are inline.

## Test plan
- Reset, then fetch at 0x0 with RAM bytes 13 05 00 00: `if_rdy` at T+6, `if_data`=0x00000513, `if_is_compressed`=0.
- Fetch at 0x4 with bytes 01 45: `if_rdy` at T+4, `if_data`=0x00004501, `if_is_compressed`=1; only addresses 0x4 and 0x5 issued.
- Fetch and 4-byte load asserted the same cycle after reset: LSB granted first (`prio_lsb`=1); fetch granted the cycle after `lsb_rdy`. Repeat with both requesting: fetch wins.
- 1-byte store 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles: `mem_wr`=0 for those cycles, then one write of 0x41; `lsb_rdy` at T+5.
- Flush at T+3 of a fetch: no `if_rdy`, state IDLE; a new fetch at the corrected PC completes normally. Flush during a 4-byte store: all 4 bytes written and `lsb_rdy` pulsed.
- `rdy_in` low for 2 cycles mid-load of 2 bytes at 0x100 (bytes AA BB): `lsb_rdata`=0x0000BBAA, rdy delayed by 2 cycles.
